line_mem_ctrl: RTL and testbench
================================

# line_mem_ctrl

Memory-side responder for the CPU's 256-bit cache-line port (the addr/data/we/rd/ack interface driven by the instruction/data cache arbiter). It accepts one line read or line write at a time and serialises it into eight 32-bit beats on a single-port synchronous word RAM with fixed read latency. On a read it reassembles the line, and in both cases it returns an ack to the requester. The block sits between the CPU top and the on-chip block RAM.

## Interface
Parameters:
- ADDR_W, 14, word-address width of the RAM (2^ADDR_W 32-bit words)
- RD_LATENCY, 1, RAM cycles from ram_en_o to valid ram_data_i; legal range 1..4

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_addr_i  in  32  byte address of line; bits [4:0] ignored, bits above ADDR_W+1 ignored (aliasing)
- mem_data_i  in  256  write line
- mem_data_o  out  256  read line
- mem_we_i  in  1  line write request
- mem_rd_i  in  1  line read request
- mem_ack_o  out  1  transaction complete
- ram_addr_o  out  ADDR_W  word address
- ram_data_o  out  32  write word
- ram_data_i  in  32  read word
- ram_en_o  out  1  RAM access enable
- ram_we_o  out  1  RAM write enable (only with ram_en_o)

## Operation
- States: IDLE, WRITE, READ, DRAIN, ACK.
- IDLE: on an edge with mem_we_i=1, latch the address and data, then go to WRITE. Otherwise, if mem_rd_i=1, latch the address and go to READ. If both are high, the write wins.
- Beat k (0..7) maps to line bits [32k+31:32k] and to RAM word {mem_addr_i[ADDR_W+1:5], k[2:0]}.
- WRITE: for 8 cycles drive ram_en_o=ram_we_o=1 with beats 0..7 in order, then go to ACK.
- READ: for 8 cycles drive ram_en_o=1, ram_we_o=0 with addresses beats 0..7. A RD_LATENCY-deep valid pipe tags each return. The beat is captured into its line slot on the edge where its tag is valid. After issuing beat 7, go to DRAIN.
- DRAIN: wait until beat 7 has been captured, then go to ACK.
- ACK: hold mem_ack_o=1 while mem_rd_i|mem_we_i is high (four-phase handshake). Return to IDLE on the first edge where both are low. No new request is accepted in ACK.
- mem_data_o is a register. It updates only during read captures and is stable from ack until the next read begins capturing.
- The requester holds mem_addr_i/mem_data_i/request stable until ack. Inputs are not resampled after the IDLE latch.
- Reset, including mid-transaction: state=IDLE, beat counters=0, valid pipe cleared, mem_ack_o=0, ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_data_o=0, mem_data_o=0. A partially written line stays partially written; no rollback.

## Timing
- Request seen at edge E0; first beat is driven in the cycle after E0.
- Write: beats occupy cycles 1..8 after E0; mem_ack_o rises in cycle 9.
- Read: issue in cycles 1..8; beat 7 is captured at the end of cycle 8+RD_LATENCY; mem_ack_o rises in cycle 9+RD_LATENCY. For RD_LATENCY=1 that is cycle 10.
- mem_ack_o falls one cycle after the requester drops the request. A new request can then be seen in IDLE at the earliest on the edge after re-entering IDLE.
- Minimum back-to-back write throughput: one line per 11 cycles.
- No combinational path from any mem_* input to any output.

## Structure
- The shared package holds LINE_BITS=256, WORD_BITS=32, WORDS_PER_LINE=8, BEAT_W=3, and the state enum.
- One sub-module is natural: rd_valid_pipe. It is a RD_LATENCY-stage shift of {valid, beat index} with synchronous clear, used for read capture.
- The main block holds the FSM, the issue counter, and the latched address and data.

## Test plan
- Write line 0x00001020 with words 0x11111111..0x88888888. Required: 8 beats on ram_addr_o 0x408..0x40F, ram_we_o high for exactly 8 cycles, ack in cycle 9.
- Read the same line back with RD_LATENCY=1 and with RD_LATENCY=3. Required: mem_data_o = {0x88888888,…,0x11111111}, ack in cycle 10 and cycle 12 respectively.
- Assert mem_rd_i and mem_we_i together at address 0x40. Required: a write is performed (ram_we_o high) and no read beats are issued.
- Requester holds rd high for 5 cycles after ack. Required: ack stays high for those 5 cycles, falls one cycle after rd drops, and no second transaction starts.
- Assert rst during write beat 4. Required: the next cycle shows ram_en_o=0, ram_we_o=0, mem_ack_o=0, and a fresh read of the line returns beats 0..3 new and 4..7 old.
- Use address 0xFFFF0000 with ADDR_W=14. Required: the access aliases to word 0x0000..0x0007 with no error.

Source files
------------

// File: rtl/line_mem_ctrl_pkg.sv
// Shared constants and state type for the cache-line memory responder.
package line_mem_ctrl_pkg;

    localparam int unsigned LINE_BITS      = 256;
    localparam int unsigned WORD_BITS      = 32;
    localparam int unsigned WORDS_PER_LINE = 8;
    localparam int unsigned BEAT_W         = 3;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StAck
    } state_e;

endpackage

// File: rtl/line_mem_ctrl_if.sv
// Cache-line request/ack bus between the CPU-side requester and line_mem_ctrl.
interface line_mem_ctrl_if;
    import line_mem_ctrl_pkg::*;

    logic [31:0]          mem_addr_i;
    logic [LINE_BITS-1:0] mem_data_i;
    logic [LINE_BITS-1:0] mem_data_o;
    logic                 mem_we_i;
    logic                 mem_rd_i;
    logic                 mem_ack_o;

    modport master (
        output mem_addr_i, mem_data_i, mem_we_i, mem_rd_i,
        input  mem_data_o, mem_ack_o
    );

    modport slave (
        input  mem_addr_i, mem_data_i, mem_we_i, mem_rd_i,
        output mem_data_o, mem_ack_o
    );

endinterface

// File: rtl/line_mem_ctrl_rd_valid_pipe.sv
// Delay line of {valid, beat index} matching the RAM read latency, so each
// returning word knows which line slot it belongs to.
module line_mem_ctrl_rd_valid_pipe
    import line_mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [BEAT_W-1:0] beat_i,
    output logic              valid_o,
    output logic [BEAT_W-1:0] beat_o
);

    logic [DEPTH-1:0]  valid_q;
    logic [BEAT_W-1:0] beat_q [DEPTH];

    // Shift register stages; reset clears in-flight tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                beat_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            beat_q[0]  <= beat_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                beat_q[i]  <= beat_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign beat_o  = beat_q[DEPTH-1];

endmodule

// File: rtl/line_mem_ctrl.sv
// Serialises 256-bit line reads/writes into eight 32-bit beats on a
// single-port synchronous RAM and acks the requester with a four-phase
// handshake.
module line_mem_ctrl
    import line_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    line_mem_ctrl_if.slave       bus,
    output logic [ADDR_W-1:0]    ram_addr_o,
    output logic [WORD_BITS-1:0] ram_data_o,
    input  logic [WORD_BITS-1:0] ram_data_i,
    output logic                 ram_en_o,
    output logic                 ram_we_o
);

    localparam int unsigned LADDR_W = ADDR_W - BEAT_W;
    localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(WORDS_PER_LINE - 1);

    state_e               state_q, state_d;
    logic [BEAT_W-1:0]    cnt_q, cnt_d;
    logic [LADDR_W-1:0]   laddr_q, laddr_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic                 cap_valid;
    logic [BEAT_W-1:0]    cap_beat;

    line_mem_ctrl_rd_valid_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (state_q == StRead),
        .beat_i  (cnt_q),
        .valid_o (cap_valid),
        .beat_o  (cap_beat)
    );

    // FSM next state, beat issue and RAM drive; outputs depend only on registers.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        laddr_d       = laddr_q;
        wdata_d       = wdata_q;
        ram_en_o      = 1'b0;
        ram_we_o      = 1'b0;
        ram_addr_o    = '0;
        ram_data_o    = '0;
        bus.mem_ack_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Write wins when both requests arrive together.
                if (bus.mem_we_i) begin
                    laddr_d = bus.mem_addr_i[ADDR_W+1:5];
                    wdata_d = bus.mem_data_i;
                    state_d = StWrite;
                end else if (bus.mem_rd_i) begin
                    laddr_d = bus.mem_addr_i[ADDR_W+1:5];
                    state_d = StRead;
                end
            end
            StWrite: begin
                ram_en_o   = 1'b1;
                ram_we_o   = 1'b1;
                ram_addr_o = {laddr_q, cnt_q};
                ram_data_o = wdata_q[int'(cnt_q) * WORD_BITS +: WORD_BITS];
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LastBeat) begin
                    state_d = StAck;
                end
            end
            StRead: begin
                ram_en_o   = 1'b1;
                ram_addr_o = {laddr_q, cnt_q};
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LastBeat) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (cap_valid && cap_beat == LastBeat) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                bus.mem_ack_o = 1'b1;
                if (!(bus.mem_rd_i || bus.mem_we_i)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Drop each tagged return word into its slot of the read line.
    always_comb begin
        rdata_d = rdata_q;
        if (cap_valid) begin
            rdata_d[int'(cap_beat) * WORD_BITS +: WORD_BITS] = ram_data_i;
        end
    end

    // State, counter and line registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            laddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            laddr_q <= laddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.mem_data_o = rdata_q;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Self-checking bench: two responders (read latency 1 and 3), each with its
// own behavioural RAM, checked against a word-array model of memory.
module tb_line_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_clr = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Shared request drive, steered to one DUT by sel.
    logic         sel = 1'b0;
    logic [31:0]  drv_addr = '0;
    logic [255:0] drv_wdata = '0;
    logic         drv_we = 1'b0;
    logic         drv_rd = 1'b0;

    line_mem_ctrl_if bif1 ();
    line_mem_ctrl_if bif3 ();

    assign bif1.mem_addr_i = drv_addr;
    assign bif1.mem_data_i = drv_wdata;
    assign bif1.mem_we_i   = drv_we & ~sel;
    assign bif1.mem_rd_i   = drv_rd & ~sel;
    assign bif3.mem_addr_i = drv_addr;
    assign bif3.mem_data_i = drv_wdata;
    assign bif3.mem_we_i   = drv_we & sel;
    assign bif3.mem_rd_i   = drv_rd & sel;

    logic [13:0] ra1, ra3;
    logic [31:0] rwd1, rwd3, rrd1, rrd3;
    logic        ren1, ren3, rwe1, rwe3;

    line_mem_ctrl #(.ADDR_W(14), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bif1), .ram_addr_o(ra1), .ram_data_o(rwd1),
        .ram_data_i(rrd1), .ram_en_o(ren1), .ram_we_o(rwe1)
    );

    line_mem_ctrl #(.ADDR_W(14), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bif3), .ram_addr_o(ra3), .ram_data_o(rwd3),
        .ram_data_i(rrd3), .ram_en_o(ren3), .ram_we_o(rwe3)
    );

    // Behavioural synchronous RAMs with 1- and 3-cycle read latency.
    logic [31:0] ram1 [0:16383];
    logic [31:0] ram3 [0:16383];
    logic [31:0] p1;
    logic [31:0] p3 [0:2];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16384; i++) ram1[i] <= '0;
        end else if (ren1 && rwe1) begin
            ram1[ra1] <= rwd1;
        end
        p1 <= ram1[ra1];
    end
    assign rrd1 = p1;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16384; i++) ram3[i] <= '0;
        end else if (ren3 && rwe3) begin
            ram3[ra3] <= rwd3;
        end
        p3[0] <= ram3[ra3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rrd3 = p3[2];

    // Observed view of the selected DUT.
    wire         o_en    = sel ? ren3 : ren1;
    wire         o_we    = sel ? rwe3 : rwe1;
    wire [13:0]  o_addr  = sel ? ra3 : ra1;
    wire [31:0]  o_wdata = sel ? rwd3 : rwd1;
    wire         o_ack   = sel ? bif3.mem_ack_o : bif1.mem_ack_o;
    wire [255:0] o_rdata = sel ? bif3.mem_data_o : bif1.mem_data_o;

    // Reference model: plain word memories per DUT.
    logic [31:0]  ref1 [0:16383];
    logic [31:0]  ref3 [0:16383];
    logic [255:0] last_rd [2];

    function automatic logic [13:0] beat_addr(input logic [31:0] a, input int k);
        logic [31:0] t;
        t = ((a >> 2) & 32'h0000_3FF8) | 32'(k);
        return t[13:0];
    endfunction

    function automatic logic [255:0] ref_line(input bit s, input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = s ? ref3[beat_addr(a, k)] : ref1[beat_addr(a, k)];
        return l;
    endfunction

    task automatic ref_write(input bit s, input logic [31:0] a, input logic [255:0] d, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            if (s) ref3[beat_addr(a, k)] = d[32*k +: 32];
            else   ref1[beat_addr(a, k)] = d[32*k +: 32];
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom();
        return l;
    endfunction

    // Per-transaction observations, indexed by cycle after the request edge.
    logic         log_en [64];
    logic         log_we [64];
    logic [13:0]  log_addr [64];
    logic [31:0]  log_data [64];
    int           ack_cyc, hold_hi, stray_en, n_we_cyc, n_rd_cyc;
    bit           ack_fell;
    logic [255:0] rd_line;

    task automatic run_txn(input bit s, input bit we, input bit rd, input logic [31:0] a,
                           input logic [255:0] d, input int hold);
        @(negedge clk);
        sel = s; drv_addr = a; drv_wdata = d; drv_we = we; drv_rd = rd;
        ack_cyc = 0; hold_hi = 0; stray_en = 0; n_we_cyc = 0; n_rd_cyc = 0;
        for (int c = 1; c < 40 && ack_cyc == 0; c++) begin
            @(negedge clk);
            log_en[c] = o_en; log_we[c] = o_we; log_addr[c] = o_addr; log_data[c] = o_wdata;
            if (o_en && o_we) n_we_cyc++;
            if (o_en && !o_we) n_rd_cyc++;
            if (o_ack) begin
                ack_cyc = c;
                rd_line = o_rdata;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (o_ack) hold_hi++;
            if (o_en) stray_en++;
        end
        drv_we = 1'b0; drv_rd = 1'b0;
        @(negedge clk);
        ack_fell = !o_ack;
        if (o_en) stray_en++;
        @(negedge clk);
        if (o_en) stray_en++;
    endtask

    task automatic test_reset();
        rst = 1'b1; ram_clr = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; ram_clr = 1'b0;
        for (int i = 0; i < 16384; i++) begin ref1[i] = '0; ref3[i] = '0; end
        last_rd[0] = '0; last_rd[1] = '0;
        @(negedge clk);
        n_cmp++;
        if ({ren1, rwe1, bif1.mem_ack_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl1: got en/we/ack %b%b%b want 000", ren1, rwe1, bif1.mem_ack_o);
        end
        n_cmp++;
        if ({ra1, rwd1} !== 46'd0) begin
            n_fail++; $display("FAIL reset_ram_bus1: got addr %h data %h want 0 0", ra1, rwd1);
        end
        n_cmp++;
        if (bif1.mem_data_o !== 256'd0) begin
            n_fail++; $display("FAIL reset_rdata1: got %h want 0", bif1.mem_data_o);
        end
        n_cmp++;
        if ({ren3, rwe3, bif3.mem_ack_o, bif3.mem_data_o} !== 259'd0) begin
            n_fail++; $display("FAIL reset_dut3: got en/we/ack %b%b%b rdata %h want all 0",
                               ren3, rwe3, bif3.mem_ack_o, bif3.mem_data_o);
        end
    endtask

    task automatic test_write_line(input bit s);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'h1111_1111 * (k + 1);
        run_txn(s, 1'b1, 1'b0, 32'h0000_1020, l, 0);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if ({log_en[k+1], log_we[k+1], log_addr[k+1], log_data[k+1]} !==
                {2'b11, 14'h408 + 14'(k), l[32*k +: 32]}) begin
                n_fail++;
                $display("FAIL write_beat%0d: got en/we %b%b addr %h data %h want 11 %h %h", k,
                         log_en[k+1], log_we[k+1], log_addr[k+1], log_data[k+1],
                         14'h408 + 14'(k), l[32*k +: 32]);
            end
        end
        n_cmp++;
        if (n_we_cyc != 8 || ack_cyc != 9) begin
            n_fail++; $display("FAIL write_timing: got we_cycles %0d ack_cycle %0d want 8 9", n_we_cyc, ack_cyc);
        end
        ref_write(s, 32'h0000_1020, l, 8);
    endtask

    task automatic test_read_line(input bit s);
        logic [255:0] l;
        int           want_ack;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'h1111_1111 * (k + 1);
        want_ack = s ? 12 : 10;
        run_txn(s, 1'b0, 1'b1, 32'h0000_1020, '0, 0);
        n_cmp++;
        if (rd_line !== l) begin
            n_fail++; $display("FAIL read_line_lat%0d: got %h want %h", s ? 3 : 1, rd_line, l);
        end
        n_cmp++;
        if (ack_cyc != want_ack || n_rd_cyc != 8 || n_we_cyc != 0) begin
            n_fail++; $display("FAIL read_timing_lat%0d: got ack %0d rd %0d we %0d want %0d 8 0",
                               s ? 3 : 1, ack_cyc, n_rd_cyc, n_we_cyc, want_ack);
        end
        last_rd[s] = l;
    endtask

    task automatic test_both_req();
        logic [255:0] l = rand_line();
        run_txn(1'b0, 1'b1, 1'b1, 32'h0000_0040, l, 0);
        n_cmp++;
        if (n_we_cyc != 8 || n_rd_cyc != 0 || ack_cyc != 9) begin
            n_fail++; $display("FAIL both_req_write_wins: got we %0d rd %0d ack %0d want 8 0 9",
                               n_we_cyc, n_rd_cyc, ack_cyc);
        end
        ref_write(1'b0, 32'h0000_0040, l, 8);
        run_txn(1'b0, 1'b0, 1'b1, 32'h0000_0040, '0, 0);
        n_cmp++;
        if (rd_line !== l) begin
            n_fail++; $display("FAIL both_req_readback: got %h want %h", rd_line, l);
        end
        last_rd[0] = l;
    endtask

    task automatic test_hold_ack();
        run_txn(1'b0, 1'b0, 1'b1, 32'h0000_1020, '0, 5);
        n_cmp++;
        if (hold_hi != 5 || !ack_fell || stray_en != 0) begin
            n_fail++; $display("FAIL hold_ack: got held %0d fell %0d stray %0d want 5 1 0",
                               hold_hi, ack_fell, stray_en);
        end
        n_cmp++;
        if (rd_line !== ref_line(1'b0, 32'h0000_1020)) begin
            n_fail++; $display("FAIL hold_ack_data: got %h want %h", rd_line, ref_line(1'b0, 32'h0000_1020));
        end
        last_rd[0] = rd_line;
    endtask

    task automatic test_reset_mid_write();
        logic [255:0] l = rand_line();
        @(negedge clk);
        sel = 1'b0; drv_addr = 32'h0000_1020; drv_wdata = l; drv_we = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1; drv_we = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ren1, rwe1, bif1.mem_ack_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid_write: got en/we/ack %b%b%b want 000", ren1, rwe1, bif1.mem_ack_o);
        end
        rst = 1'b0;
        ref_write(1'b0, 32'h0000_1020, l, 4);
        last_rd[0] = '0; last_rd[1] = '0;
        run_txn(1'b0, 1'b0, 1'b1, 32'h0000_1020, '0, 0);
        n_cmp++;
        if (rd_line !== ref_line(1'b0, 32'h0000_1020)) begin
            n_fail++; $display("FAIL reset_partial_line: got %h want %h", rd_line, ref_line(1'b0, 32'h0000_1020));
        end
        last_rd[0] = rd_line;
    endtask

    task automatic test_alias();
        logic [255:0] l = rand_line();
        run_txn(1'b0, 1'b1, 1'b0, 32'hFFFF_0000, l, 0);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (log_addr[k+1] !== 14'(k) || !log_we[k+1]) begin
                n_fail++; $display("FAIL alias_beat%0d: got addr %h we %b want %h 1", k, log_addr[k+1], log_we[k+1], 14'(k));
            end
        end
        ref_write(1'b0, 32'hFFFF_0000, l, 8);
        run_txn(1'b0, 1'b0, 1'b1, 32'h0000_0000, '0, 0);
        n_cmp++;
        if (rd_line !== l || ack_cyc != 10) begin
            n_fail++; $display("FAIL alias_readback: got %h ack %0d want %h 10", rd_line, ack_cyc, l);
        end
        last_rd[0] = l;
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            bit           s  = 1'($urandom_range(0, 1));
            int           kd = $urandom_range(0, 2);
            bit           we = (kd != 1);
            bit           rd = (kd != 0);
            int unsigned  idx = ($urandom_range(0, 3) == 3) ? 32'h81 : $urandom_range(0, 2);
            logic [31:0]  a = ($urandom() & 32'hFFFF_0000) | (idx << 5) | ($urandom() & 32'h1F);
            logic [255:0] d = rand_line();
            int           want_ack = we ? 9 : (s ? 12 : 10);
            run_txn(s, we, rd, a, d, $urandom_range(0, 2));
            for (int k = 0; k < 8; k++) begin
                n_cmp++;
                if ({log_en[k+1], log_we[k+1], log_addr[k+1]} !== {1'b1, we, beat_addr(a, k)} ||
                    (we && log_data[k+1] !== d[32*k +: 32])) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: got en/we %b%b addr %h data %h want 1%b %h %h", it, k,
                             log_en[k+1], log_we[k+1], log_addr[k+1], log_data[k+1], we,
                             beat_addr(a, k), we ? d[32*k +: 32] : log_data[k+1]);
                end
            end
            n_cmp++;
            if (ack_cyc != want_ack || !ack_fell || stray_en != 0) begin
                n_fail++; $display("FAIL rand%0d_handshake: got ack %0d fell %0d stray %0d want %0d 1 0",
                                   it, ack_cyc, ack_fell, stray_en, want_ack);
            end
            if (we) begin
                n_cmp++;
                if (rd_line !== last_rd[s]) begin
                    n_fail++; $display("FAIL rand%0d_rdata_stable: got %h want %h", it, rd_line, last_rd[s]);
                end
                ref_write(s, a, d, 8);
            end else begin
                n_cmp++;
                if (rd_line !== ref_line(s, a)) begin
                    n_fail++; $display("FAIL rand%0d_read: got %h want %h", it, rd_line, ref_line(s, a));
                end
                last_rd[s] = ref_line(s, a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_line(1'b0);
        test_read_line(1'b0);
        test_write_line(1'b1);
        test_read_line(1'b1);
        test_both_req();
        test_hold_ack();
        test_reset_mid_write();
        test_alias();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish within time limit, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
